// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I decode definitions.
//   - opcode constants for the nine base-ISA major opcodes
//   - alu_op_e: ALU operation code carried to execute (4 bits)
//   - imm_type_e: immediate format selector
//   - id_ex_t: payload of the ID/EX pipeline register
//   - helpers: ALU op from funct3/funct7[5], immediate format from opcode
package riscv_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] rs1_val;
    logic [DATA_W-1:0] rs2_val;
    logic [DATA_W-1:0] imm;
    logic [4:0]        rd;
    alu_op_e           alu_op;
    logic              alu_src_imm;
    logic              reg_wr;
    logic              mem_rd;
    logic              mem_wr;
    logic              branch;
    logic              jump;
    logic              illegal;
    logic [2:0]        funct3;
  } id_ex_t;

  // funct7[5] selects SUB only for register-register ops; it selects SRA
  // for both OP and OP-IMM (SRAI).
  function automatic alu_op_e alu_decode(input logic [2:0] f3,
                                         input logic       f7b5,
                                         input logic       is_op);
    alu_op_e op;
    unique case (f3)
      3'd0:    op = (is_op && f7b5) ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = f7b5 ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic imm_type_e imm_type_of(input logic [6:0] opcode);
    imm_type_e t;
    unique case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: t = IMM_I;
      OPC_STORE:                      t = IMM_S;
      OPC_BRANCH:                     t = IMM_B;
      OPC_LUI, OPC_AUIPC:             t = IMM_U;
      OPC_JAL:                        t = IMM_J;
      default:                        t = IMM_NONE;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/gerador_imediato.sv
// gerador_imediato: combinational RV32I immediate generator.
//   instr : 32-bit instruction word
//   imm   : sign-extended immediate (0 for formats without one);
//           shift-immediates are consumed from imm[4:0] downstream
module gerador_imediato
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm
);

  imm_type_e imm_type;

  always_comb begin
    imm_type = imm_type_of(instr[6:0]);
    imm      = '0;
    unique case (imm_type)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'h000};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                      instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decodificador.sv
// decodificador: RV32I decode stage with ID/EX pipeline register.
//   clk, rst          : clock, synchronous active-high reset
//   if_valid/if_ready : fetch handshake; if_instr/if_pc instruction and address
//   rs1, rs2          : regfile read addresses (combinational from if_instr)
//   read1, read2      : regfile read data
//   wb_wr/wb_rd/wb_data : writeback port, forwarded into decode when BYPASS_WB
//   flush             : redirect from EX, kills decode and blocks acceptance
//   ex_valid/ex_ready : ID/EX handshake; ex_* registered decoded instruction
module decodificador
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter bit          BYPASS_WB = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  input  logic [XLEN-1:0] read1,
  input  logic [XLEN-1:0] read2,
  input  logic            wb_wr,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd,
  output logic [3:0]      ex_alu_op,
  output logic            ex_alu_src_imm,
  output logic            ex_reg_wr,
  output logic            ex_mem_rd,
  output logic            ex_mem_wr,
  output logic            ex_branch,
  output logic            ex_jump,
  output logic            ex_illegal,
  output logic [2:0]      ex_funct3
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        f7b5;
  logic [31:0] imm;
  logic        uses_rs1;
  logic        uses_rs2;
  logic        hazard;
  logic        load;
  id_ex_t      dec;
  id_ex_t      ex_d, ex_q;
  logic        ex_valid_d, ex_valid_q;

  assign opcode = if_instr[6:0];
  assign rd     = if_instr[11:7];
  assign funct3 = if_instr[14:12];
  assign rs1    = if_instr[19:15];
  assign rs2    = if_instr[24:20];
  assign f7b5   = if_instr[30];

  gerador_imediato u_imm (
    .instr (if_instr),
    .imm   (imm)
  );

  // Load-use: a load sitting in ID/EX cannot feed this instruction yet.
  always_comb begin
    uses_rs1 = !(opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL);
    uses_rs2 = (opcode == OPC_OP || opcode == OPC_STORE || opcode == OPC_BRANCH);
    hazard   = ex_valid_q && ex_q.mem_rd && (ex_q.rd != 5'd0) &&
               ((uses_rs1 && ex_q.rd == rs1) || (uses_rs2 && ex_q.rd == rs2));
  end

  assign if_ready = (!ex_valid_q || ex_ready) && !hazard && !flush;
  assign load     = if_valid && if_ready;

  always_comb begin
    dec             = '0;
    dec.pc          = if_pc;
    dec.imm         = imm;
    dec.funct3      = funct3;
    dec.alu_op      = ALU_ADD;

    if (rs1 == 5'd0)
      dec.rs1_val = '0;
    else if (BYPASS_WB && wb_wr && wb_rd == rs1)
      dec.rs1_val = wb_data;
    else
      dec.rs1_val = read1;

    if (rs2 == 5'd0)
      dec.rs2_val = '0;
    else if (BYPASS_WB && wb_wr && wb_rd == rs2)
      dec.rs2_val = wb_data;
    else
      dec.rs2_val = read2;

    unique case (opcode)
      OPC_OP: begin
        dec.reg_wr = 1'b1;
        dec.alu_op = alu_decode(funct3, f7b5, 1'b1);
      end
      OPC_OP_IMM: begin
        dec.reg_wr      = 1'b1;
        dec.alu_src_imm = 1'b1;
        dec.alu_op      = alu_decode(funct3, f7b5, 1'b0);
      end
      OPC_LOAD: begin
        dec.mem_rd      = 1'b1;
        dec.reg_wr      = 1'b1;
        dec.alu_src_imm = 1'b1;
      end
      OPC_STORE: begin
        dec.mem_wr      = 1'b1;
        dec.alu_src_imm = 1'b1;
      end
      OPC_BRANCH: begin
        dec.branch = 1'b1;
        dec.alu_op = ALU_SUB;
      end
      OPC_JAL, OPC_JALR: begin
        dec.jump   = 1'b1;
        dec.reg_wr = 1'b1;
      end
      OPC_LUI: begin
        dec.reg_wr      = 1'b1;
        dec.alu_op      = ALU_PASS_B;
        dec.alu_src_imm = 1'b1;
      end
      OPC_AUIPC: begin
        dec.reg_wr      = 1'b1;
        dec.alu_src_imm = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase

    dec.rd = dec.reg_wr ? rd : 5'd0;
  end

  // Priority: flush, then new load, then stall-hold, else drain to empty.
  always_comb begin
    ex_d       = ex_q;
    ex_valid_d = ex_valid_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (load) begin
      ex_valid_d = 1'b1;
      ex_d       = dec;
    end else if (!(ex_valid_q && !ex_ready)) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_q       <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_q       <= ex_d;
    end
  end

  assign ex_valid       = ex_valid_q;
  assign ex_pc          = ex_q.pc;
  assign ex_rs1_val     = ex_q.rs1_val;
  assign ex_rs2_val     = ex_q.rs2_val;
  assign ex_imm         = ex_q.imm;
  assign ex_rd          = ex_q.rd;
  assign ex_alu_op      = ex_q.alu_op;
  assign ex_alu_src_imm = ex_q.alu_src_imm;
  assign ex_reg_wr      = ex_q.reg_wr;
  assign ex_mem_rd      = ex_q.mem_rd;
  assign ex_mem_wr      = ex_q.mem_wr;
  assign ex_branch      = ex_q.branch;
  assign ex_jump        = ex_q.jump;
  assign ex_illegal     = ex_q.illegal;
  assign ex_funct3      = ex_q.funct3;

endmodule

// File: tb/tb_decodificador.sv
module tb_decodificador;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_valid = 1'b0;
  logic        if_ready;
  logic [31:0] if_instr = '0;
  logic [31:0] if_pc = '0;
  logic [4:0]  rs1, rs2;
  logic [31:0] read1 = '0, read2 = '0;
  logic        wb_wr = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        flush = 1'b0;
  logic        ex_valid;
  logic        ex_ready = 1'b1;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]  ex_rd;
  logic [3:0]  ex_alu_op;
  logic        ex_alu_src_imm, ex_reg_wr, ex_mem_rd, ex_mem_wr;
  logic        ex_branch, ex_jump, ex_illegal;
  logic [2:0]  ex_funct3;

  int checks = 0;
  int failures = 0;

  // ALU codes: ADD=0 SUB=1 PASS_B=10
  localparam logic [31:0] A_ADD = 32'd0;
  localparam logic [31:0] A_SUB = 32'd1;
  localparam logic [31:0] A_PASSB = 32'd10;

  decodificador #(.XLEN(32), .BYPASS_WB(1'b1)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .rs1(rs1), .rs2(rs2), .read1(read1), .read2(read2),
    .wb_wr(wb_wr), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm),
    .ex_rd(ex_rd), .ex_alu_op(ex_alu_op), .ex_alu_src_imm(ex_alu_src_imm),
    .ex_reg_wr(ex_reg_wr), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_illegal(ex_illegal),
    .ex_funct3(ex_funct3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    step();
    step();
    chk("rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_imm", ex_imm, 32'd0);
    chk("rst_rd", {27'd0, ex_rd}, 32'd0);
    chk("rst_pc", ex_pc, 32'd0);
    rst = 1'b0;

    // addi x5,x0,0x123
    if_valid = 1'b1; if_instr = 32'h12300293; if_pc = 32'h100; read1 = 32'hDEAD;
    #1;
    chk("addi_rs1_addr", {27'd0, rs1}, 32'd0);
    chk("addi_rs2_addr", {27'd0, rs2}, 32'd3);
    step();
    chk("addi_valid", {31'd0, ex_valid}, 32'd1);
    chk("addi_rd", {27'd0, ex_rd}, 32'd5);
    chk("addi_imm", ex_imm, 32'h00000123);
    chk("addi_alu", {28'd0, ex_alu_op}, A_ADD);
    chk("addi_src_imm", {31'd0, ex_alu_src_imm}, 32'd1);
    chk("addi_reg_wr", {31'd0, ex_reg_wr}, 32'd1);
    chk("addi_pc", ex_pc, 32'h100);
    chk("addi_x0_val", ex_rs1_val, 32'd0);

    // lw x6,4(x5) then add x7,x6,x5 -> one bubble
    if_instr = 32'h0042A303; if_pc = 32'h104; read1 = 32'h1000;
    #1;
    chk("lw_if_ready", {31'd0, if_ready}, 32'd1);
    step();
    chk("lw_mem_rd", {31'd0, ex_mem_rd}, 32'd1);
    chk("lw_rd", {27'd0, ex_rd}, 32'd6);
    chk("lw_imm", ex_imm, 32'd4);
    chk("lw_rs1_val", ex_rs1_val, 32'h1000);
    chk("lw_funct3", {29'd0, ex_funct3}, 32'd2);
    if_instr = 32'h005303B3; if_pc = 32'h108; read1 = 32'h11; read2 = 32'h22;
    #1;
    chk("hz_if_ready", {31'd0, if_ready}, 32'd0);
    step();
    chk("hz_bubble", {31'd0, ex_valid}, 32'd0);
    chk("hz_release", {31'd0, if_ready}, 32'd1);
    step();
    chk("add_valid", {31'd0, ex_valid}, 32'd1);
    chk("add_rd", {27'd0, ex_rd}, 32'd7);
    chk("add_alu", {28'd0, ex_alu_op}, A_ADD);
    chk("add_src_imm", {31'd0, ex_alu_src_imm}, 32'd0);
    chk("add_rs1_val", ex_rs1_val, 32'h11);
    chk("add_rs2_val", ex_rs2_val, 32'h22);
    chk("add_pc", ex_pc, 32'h108);

    // beq x0,x0,-8 (rd field nonzero, must be forced to 0)
    if_instr = 32'hFE000CE3; if_pc = 32'h10C;
    step();
    chk("beq_imm", ex_imm, 32'hFFFFFFF8);
    chk("beq_branch", {31'd0, ex_branch}, 32'd1);
    chk("beq_alu", {28'd0, ex_alu_op}, A_SUB);
    chk("beq_reg_wr", {31'd0, ex_reg_wr}, 32'd0);
    chk("beq_rd", {27'd0, ex_rd}, 32'd0);

    // sw x6,8(x5)
    if_instr = 32'h0062A423; if_pc = 32'h110;
    step();
    chk("sw_mem_wr", {31'd0, ex_mem_wr}, 32'd1);
    chk("sw_imm", ex_imm, 32'd8);
    chk("sw_rd", {27'd0, ex_rd}, 32'd0);
    chk("sw_src_imm", {31'd0, ex_alu_src_imm}, 32'd1);

    // lui x8,0x12345
    if_instr = 32'h12345437; if_pc = 32'h114;
    step();
    chk("lui_imm", ex_imm, 32'h12345000);
    chk("lui_alu", {28'd0, ex_alu_op}, A_PASSB);

    // Bypass on rs1: addi x1,x5,0
    if_instr = 32'h00028093; if_pc = 32'h118; read1 = 32'h0;
    wb_wr = 1'b1; wb_rd = 5'd5; wb_data = 32'hAAAABBBB;
    step();
    chk("byp_rs1", ex_rs1_val, 32'hAAAABBBB);
    wb_rd = 5'd0; read1 = 32'h5555; if_pc = 32'h11C;
    step();
    chk("byp_rd0", ex_rs1_val, 32'h5555);
    // Bypass on rs2: add x7,x6,x5
    if_instr = 32'h005303B3; if_pc = 32'h140; read1 = 32'h11; read2 = 32'h22;
    wb_rd = 5'd5; wb_data = 32'h12345678;
    step();
    chk("byp_rs2", ex_rs2_val, 32'h12345678);
    chk("byp_rs2_rs1", ex_rs1_val, 32'h11);
    wb_wr = 1'b0; wb_rd = 5'd0;

    // Stall: hold ex_ready low for 3 cycles with a new fetch waiting
    ex_ready = 1'b0; if_instr = 32'h12300293; if_pc = 32'h200;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_if_ready", {31'd0, if_ready}, 32'd0);
      step();
      chk("hold_valid", {31'd0, ex_valid}, 32'd1);
      chk("hold_rd", {27'd0, ex_rd}, 32'd7);
      chk("hold_pc", ex_pc, 32'h140);
    end
    flush = 1'b1;
    #1;
    chk("flush_if_ready", {31'd0, if_ready}, 32'd0);
    step();
    chk("flush_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush_no_accept", {27'd0, ex_rd}, 32'd7);
    flush = 1'b0; ex_ready = 1'b1; if_valid = 1'b0;
    step();
    chk("idle_valid", {31'd0, ex_valid}, 32'd0);

    // Illegal opcode, then reset while held
    if_valid = 1'b1; if_instr = 32'h0000007F; if_pc = 32'h300;
    step();
    chk("ill_flag", {31'd0, ex_illegal}, 32'd1);
    chk("ill_valid", {31'd0, ex_valid}, 32'd1);
    chk("ill_ctrl", {27'd0, ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_branch, ex_jump}, 32'd0);
    chk("ill_rd", {27'd0, ex_rd}, 32'd0);
    if_valid = 1'b0; ex_ready = 1'b0; rst = 1'b1;
    step();
    chk("rst2_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst2_illegal", {31'd0, ex_illegal}, 32'd0);
    chk("rst2_pc", ex_pc, 32'd0);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decodificador.md
Name: decodificador

Overview:
- RV32I instruction-decode stage between fetch and execute.
- Accepts one instruction per cycle from fetch and drives the register-file read addresses (rs1/rs2).
- Takes read1/read2 back, applies writeback bypass and generates the immediate and control signals.
- Registers everything into the ID/EX pipeline register with valid/ready handshakes, load-use stall detection and flush.

Parameters:
- XLEN, 32, datapath width (only 32 supported).
- BYPASS_WB, 1, enables same-cycle writeback-to-decode forwarding.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- if_valid  input  1  fetch offers instruction
- if_ready  output  1  decode accepts this cycle
- if_instr  input  32  instruction word
- if_pc  input  32  instruction address
- rs1  output  5  regfile read address 1 (combinational from if_instr[19:15])
- rs2  output  5  regfile read address 2 (combinational from if_instr[24:20])
- read1  input  32  regfile data for rs1
- read2  input  32  regfile data for rs2
- wb_wr  input  1  writeback write enable
- wb_rd  input  5  writeback destination
- wb_data  input  32  writeback data
- flush  input  1  branch/jump redirect from EX; kill decode contents
- ex_valid  output  1  ID/EX register holds a valid instruction
- ex_ready  input  1  EX consumes this cycle
- ex_pc, ex_rs1_val, ex_rs2_val, ex_imm  output  32 each
- ex_rd  output  5  destination register
- ex_alu_op  output  4  ALU operation code (package enum)
- ex_alu_src_imm, ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_branch, ex_jump, ex_illegal  output  1 each
- ex_funct3  output  3  passed through for branch/load/store width

Behaviour:
- Reset (rst=1 at clk edge): all ex_* outputs are 0 and ex_valid=0. Reset mid-operation discards the held instruction.
- Latency: 1 cycle. An instruction accepted at edge N appears on ex_* after edge N.
- Load enable: load = if_valid & if_ready.
- if_ready = (~ex_valid | ex_ready) & ~hazard & ~flush.
- Load-use hazard:
  - hazard = ex_valid & ex_mem_rd & (ex_rd≠0) & ((uses_rs1 & ex_rd==rs1) | (uses_rs2 & ex_rd==rs2)).
  - uses_rs1 is false for LUI, AUIPC and JAL. uses_rs2 is true only for OP, STORE and BRANCH.
  - When hazard and ex_ready: insert a bubble (ex_valid←0) and hold fetch. This gives exactly one stall cycle.
- Stall: ex_valid & ~ex_ready leaves all ex_* unchanged.
- Flush: highest priority. Next edge sets ex_valid←0 and accepts nothing (if_ready=0 that cycle), regardless of hazard or if_valid.
- Idle: with no load and no hold, ex_valid←0 when ex_ready.
- Bypass (BYPASS_WB=1): if wb_wr & wb_rd≠0 & wb_rd==rs1, ex_rs1_val←wb_data, else read1. rs2 is handled the same way. Register x0 always yields 0.
- Immediate, sign-extended to 32 bits:
  - I: LOAD, OP-IMM, JALR.
  - S: STORE.
  - B: BRANCH, bit0=0.
  - U: LUI, AUIPC, low 12 bits=0.
  - J: JAL.
  - Shift-immediates use imm[4:0].
- Control by opcode:
  - OP / OP-IMM: reg_wr=1. ALU op from funct3 plus funct7[5] (OP-IMM uses funct7[5] only for SRAI).
  - LOAD: mem_rd, reg_wr, alu ADD, src_imm.
  - STORE: mem_wr, alu ADD, src_imm.
  - BRANCH: branch, alu SUB.
  - JAL / JALR: jump, reg_wr.
  - LUI: alu PASS_B, src_imm.
  - AUIPC: alu ADD, src_imm.
- Illegal opcode: ex_illegal=1; reg_wr, mem_rd, mem_wr, branch and jump all 0; ex_valid still 1.
- ex_rd is forced to 0 when reg_wr=0.

Decomposition:
- Package riscv_pkg holds:
  - opcode constants (OPC_LOAD…OPC_LUI);
  - alu_op enum: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B;
  - imm-type enum.
- Sub-module gerador_imediato: combinational, instr→imm. Everything else lives in decodificador.

Test Plan:
- After reset, 0x12300293 (addi x5,x0,0x123) with ex_ready=1 → next cycle: ex_valid=1, ex_rd=5, ex_imm=0x00000123, alu ADD, src_imm=1, reg_wr=1, rs1 output=0.
- 0x0042A303 (lw x6,4(x5)) then 0x005303B3 (add x7,x6,x5) back-to-back:
  - one bubble cycle, with if_ready=0 and ex_valid=0;
  - then add is issued with ex_rd=7 and alu ADD.
- 0xFE000CE3 (beq x0,x0,-8) → ex_imm=0xFFFFFFF8, branch=1, alu SUB, reg_wr=0, ex_rd=0.
- Bypass: decode rs1=x5 (read1=0) while wb_wr=1, wb_rd=5, wb_data=0xAAAABBBB → ex_rs1_val=0xAAAABBBB. Repeat with wb_rd=0 → read1 value is used.
- Hold ex_ready=0 for 3 cycles with if_valid=1:
  - ex_* are stable and if_ready=0;
  - flush asserted during the hold → next edge ex_valid=0, and the fetch instruction is not accepted.
- Instruction 0x0000007F → ex_illegal=1, ex_valid=1, all write/memory controls 0. rst asserted while ex_valid=1 → ex_valid=0 after the edge.
